// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default oversampling, line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Oversampling ratio must be a power of two so the phase counter wraps naturally.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit phase counter: counts while enabled and pulses bit_done_c on the
// cycle where the count wraps from OVERSAMPLE-1 back to 0.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic bit_done_c
);

  localparam int unsigned PHASE_W = $clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign bit_done_c = en && !clr && (phase_q == PHASE_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with valid/ready byte input on the oversampling clock.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 uart_samplig_clk,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic [DATA_BITS-1:0] send_data,
  output logic                 RsTx,
  output logic                 busy
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Elaboration-time guard on the legal parameter space.
  if (!is_pow2(OVERSAMPLE) || OVERSAMPLE < 4 || OVERSAMPLE > 256 ||
      DATA_BITS < 1 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_transmitter: illegal parameter combination");
  end

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 ready_q;
  logic                 ready_d;
  logic                 busy_q;
  logic                 busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
  logic                 parity_d;
`endif

  logic transfer_c;
  logic timer_en_c;
  logic bit_done_c;

  assign transfer_c = valid && ready_q;
  assign timer_en_c = (state_q != IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk       (uart_samplig_clk),
    .reset     (reset),
    .en        (timer_en_c),
    .clr       (transfer_c),
    .bit_done_c(bit_done_c)
  );

  // Next-state, datapath and output logic; the line level lags the state by one edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = MARK;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (transfer_c) begin
          state_d   = START;
          shift_d   = send_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^send_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_done_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done_c) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_c) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done_c) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    unique case (state_q)
      START:   tx_d = SPACE;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = MARK;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge uart_samplig_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= MARK;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign RsTx  = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: table vectors, hand-written corner
// sequences and random bytes against a frame-level line model.
module tb_uart_transmitter;

  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int NBITS = 1 + DB + NPAR + SB;
  localparam int FRAME = NBITS * OS;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic          ready;
  logic [DB-1:0] send_data;
  logic          RsTx;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transmitter #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_ODD(PODD)
  ) dut (
    .uart_samplig_clk(clk),
    .reset           (reset),
    .valid           (valid),
    .ready           (ready),
    .send_data       (send_data),
    .RsTx            (RsTx),
    .busy            (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic [9:0] exp_line;   // start, data LSB first, stop; leftmost bit goes out first
    int         change_at;  // frame cycle at which send_data is disturbed (0 = never)
    logic [7:0] alt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line model: the whole frame as a bit sequence, index 0 transmitted first.
  function automatic logic [NBITS-1:0] frame_of(input logic [DB-1:0] d);
    logic [NBITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DB] = 1'(($countones(d) + PODD) % 2);
`endif
    return f;
  endfunction

  function automatic logic exp_bit(input logic [DB-1:0] d, input logic [9:0] line,
                                   input bit use_line, input int b);
    logic [NBITS-1:0] f;
    f = frame_of(d);
    if (use_line && b <= DB) return line[9-b];
    return f[b];
  endfunction

  // Present a byte and wait for ready; returns at the negedge after the transfer edge.
  task automatic send(input string tag, input logic [DB-1:0] d);
    bit ok;
    ok        = 1'b0;
    valid     = 1'b1;
    send_data = d;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_xfer"}, 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  // Called at the negedge after a transfer edge; watches the full frame.
  task automatic watch(input string tag, input logic [DB-1:0] d, input logic [9:0] line,
                       input bit use_line, input int change_at, input logic [DB-1:0] alt,
                       output int t0);
    int wrong [NBITS];
    int early;
    int b;
    foreach (wrong[i]) wrong[i] = 0;
    early = 0;
    t0    = cyc;
    check({tag, "_tx_k0"}, 32'(RsTx), 32'd1);
    check({tag, "_ready_k0"}, 32'(ready), 32'd0);
    check({tag, "_busy_k0"}, 32'(busy), 32'd1);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      b = (k - 1) / OS;
      if (RsTx !== exp_bit(d, line, use_line, b)) wrong[b]++;
      if (k < FRAME && (ready !== 1'b0 || busy !== 1'b1)) early++;
      if (k == change_at) send_data = alt;
    end
    for (int i = 0; i < NBITS; i++)
      check($sformatf("%s_bit%0d_bad_cycles", tag, i), 32'(wrong[i]), 32'd0);
    check({tag, "_ready_early_cycles"}, 32'(early), 32'd0);
    check({tag, "_ready_end"}, 32'(ready), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a;
    int t_b;
    int t_prev;
    int t_now;
    int idle_bad;
    bit held;
    bit hold_next;
    logic [7:0] d;
    logic [7:0] nd;

    vecs[0] = '{8'hA3, 10'b0110001011, 0,  8'h00};
    vecs[1] = '{8'h07, 10'b0111000001, 0,  8'h00};
    vecs[2] = '{8'h3C, 10'b0001111001, 0,  8'h00};
    vecs[3] = '{8'h00, 10'b0000000001, 0,  8'h00};
    vecs[4] = '{8'hFF, 10'b0111111111, 0,  8'h00};
    vecs[5] = '{8'h55, 10'b0101010101, 40, 8'h0F};
    vecs[6] = '{8'h0F, 10'b0111100001, 77, 8'hF0};

    reset     = 1'b1;
    valid     = 1'b0;
    send_data = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(RsTx), 32'd1);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (RsTx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    check("idle_bad_cycles", 32'(idle_bad), 32'd0);

    // Table vectors: single-cycle valid pulse, optional data disturbance mid-frame.
    foreach (vecs[i]) begin
      send($sformatf("vec%0d", i), vecs[i].d);
      valid = 1'b0;
      watch($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_line, 1'b1,
            vecs[i].change_at, vecs[i].alt, t_now);
      @(negedge clk);
    end

    // Back-to-back with valid held: 0x00 then 0xFF, data changed right after handshake.
    send("b2b_a", 8'h00);
    send_data = 8'hFF;
    watch("b2b_a", 8'h00, 10'b0000000001, 1'b1, 0, 8'h00, t_a);
    @(negedge clk);
    valid = 1'b0;
    watch("b2b_b", 8'hFF, 10'b0111111111, 1'b1, 0, 8'h00, t_b);
    check("b2b_start_gap", 32'(t_b - t_a), 32'(FRAME + 1));

    // Valid held with 0x55, data switched to 0x0F at cycle 40.
    repeat (3) @(negedge clk);
    send("hold_a", 8'h55);
    watch("hold_a", 8'h55, 10'b0101010101, 1'b1, 40, 8'h0F, t_a);
    @(negedge clk);
    valid = 1'b0;
    watch("hold_b", 8'h0F, 10'b0111100001, 1'b1, 0, 8'h00, t_b);
    check("hold_start_gap", 32'(t_b - t_a), 32'(FRAME + 1));

    // Reset at frame cycle 70, then a clean 0x3C frame.
    repeat (2) @(negedge clk);
    send("rst_a", 8'hA3);
    valid = 1'b0;
    repeat (70) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(RsTx), 32'd1);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_tx", 32'(RsTx), 32'd1);
    send("rst_b", 8'h3C);
    valid = 1'b0;
    watch("rst_b", 8'h3C, 10'b0001111001, 1'b1, 0, 8'h00, t_now);

    // Random bytes, random gaps, random back-to-back chaining.
    held   = 1'b0;
    t_prev = 0;
    d      = 8'h00;
    for (int n = 0; n < 24; n++) begin
      if (!held) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        d = 8'($urandom);
        send($sformatf("rnd%0d", n), d);
      end else begin
        @(negedge clk);
      end
      hold_next = (n < 23) && ($urandom_range(0, 1) == 1);
      nd        = 8'($urandom);
      if (hold_next) send_data = nd;
      else valid = 1'b0;
      watch($sformatf("rnd%0d", n), d, 10'h000, 1'b0, 0, 8'h00, t_now);
      if (held) check($sformatf("rnd%0d_start_gap", n), 32'(t_now - t_prev), 32'(FRAME + 1));
      t_prev = t_now;
      held   = hold_next;
      if (hold_next) d = nd;
    end

    valid = 1'b0;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
